// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg / fetch_stage_if
//
// Purpose : Shared types for the fetch stage and the instruction-bus interface
//           that connects it to instruction memory.
//
// reg_if_id_t : IF/ID pipeline register contents handed to decode
//               (valid, pc, pcPlus4, instr, instrAddr).
//
// fetch_stage_if ports (instruction bus):
//   ireq_valid     fetch -> mem  request valid
//   ireq_addr      fetch -> mem  request address (64)
//   iresp_data_ok  mem -> fetch  response for the outstanding request
//   iresp_data     mem -> fetch  instruction word (32)
//   modport master : fetch side, modport slave : memory side
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] pcPlus4;
        logic [31:0] instr;
        logic [63:0] instrAddr;
    } reg_if_id_t;

endpackage

interface fetch_stage_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Purpose : Instruction-fetch stage. Owns the architectural PC, keeps at most
//           one instruction-bus request outstanding and loads the IF/ID
//           register. Honours the global advance, decode's hold request and
//           redirects from execute (stale in-flight fetches are drained and
//           discarded).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   bus                      instruction bus (fetch_stage_if.master)
//   moduleOut                IF/ID register (reg_if_id_t)
//   ok_to_proceed            an instruction or redirect can be handed over
//   ok_to_proceed_overall    global advance; all pipeline registers gate on it
//   lwHold                   decode requests a bubble (instruction retained)
//   JumpEn, jumpTarget       redirect request and target PC
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        bus,
    output reg_if_id_t           moduleOut,
    output logic                 ok_to_proceed,
    input  logic                 ok_to_proceed_overall,
    input  logic                 lwHold,
    input  logic                 JumpEn,
    input  logic [63:0]          jumpTarget
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] drop_addr;
    logic [31:0] instr_buf;
    logic        buf_valid;
    logic        have;
    logic        buf_load;
    logic [31:0] cur;
    logic        adv;

    assign adv = ok_to_proceed_overall;

    // An instruction is available either straight off the bus or from the
    // buffer filled during an earlier stall/bubble.
    assign have = ((state == S_REQ) && bus.iresp_data_ok) ||
                  ((state == S_HOLD) && buf_valid);
    assign cur  = (state == S_HOLD) ? instr_buf : bus.iresp_data;

    assign ok_to_proceed = have || JumpEn;

    // Buffer loads on a decode bubble with data in hand, or when data arrives
    // while the pipeline is frozen.
    assign buf_load = (adv && !JumpEn && lwHold && have) ||
                      (!adv && (state == S_REQ) && bus.iresp_data_ok);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (adv) begin
                    if (JumpEn) begin
                        // Request still in flight: must drain before refetching.
                        state_nxt = bus.iresp_data_ok ? S_REQ : S_DROP;
                    end else if (lwHold) begin
                        state_nxt = have ? S_HOLD : S_REQ;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end else if (bus.iresp_data_ok) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (adv) begin
                    if (JumpEn) begin
                        state_nxt = S_REQ;
                    end else if (lwHold) begin
                        state_nxt = S_HOLD;
                    end else if (have) begin
                        state_nxt = S_REQ;
                    end
                end
            end
            S_DROP: begin
                // The stale response is discarded whatever else happens;
                // a further redirect just updates pc.
                if (bus.iresp_data_ok) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: the stale address is replayed in DROP so the bus request
    // stays stable although pc already holds the redirect target.
    always_comb begin
        bus.ireq_valid = (state == S_REQ) || (state == S_DROP);
        bus.ireq_addr  = (state == S_DROP) ? drop_addr : pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            moduleOut <= '0;
        end else if (adv) begin
            if (JumpEn) begin
                moduleOut.valid <= 1'b0;
                pc              <= jumpTarget;
                buf_valid       <= 1'b0;
            end else if (lwHold) begin
                moduleOut.valid <= 1'b0;
                if (have) begin
                    buf_valid <= 1'b1;
                end
            end else if (have) begin
                moduleOut <= '{valid:     1'b1,
                               pc:        pc,
                               pcPlus4:   pc + 64'd4,
                               instr:     cur,
                               instrAddr: pc};
                pc        <= pc + 64'd4;
                buf_valid <= 1'b0;
            end else begin
                moduleOut.valid <= 1'b0;
            end
        end else if ((state == S_REQ) && bus.iresp_data_ok) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) begin
            instr_buf <= cur;
        end
        if ((state == S_REQ) && (state_nxt == S_DROP)) begin
            drop_addr <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        adv;
    logic        lw;
    logic        jmp;
    logic [63:0] tgt;
    reg_if_id_t  mo;
    logic        okp;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    // Memory model: answers once the request has been outstanding lat cycles;
    // the instruction word is the low half of its address.
    int   lat;
    logic force_ok;
    int   wait_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (bus.ireq_valid && bus.iresp_data_ok) wait_cnt <= 0;
        else if (bus.ireq_valid) wait_cnt <= wait_cnt + 1;
    end

    assign bus.iresp_data_ok = force_ok | (bus.ireq_valid && (wait_cnt >= lat));
    assign bus.iresp_data    = bus.ireq_addr[31:0];

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .bus                   (bus),
        .moduleOut             (mo),
        .ok_to_proceed         (okp),
        .ok_to_proceed_overall (adv),
        .lwHold                (lw),
        .JumpEn                (jmp),
        .jumpTarget            (tgt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkmo(input string tag, input reg_if_id_t obs, input reg_if_id_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the stream of instructions delivered to decode must be
    // program order -- start at RESET_PC, step by 4, restart at the newest
    // redirect target -- each carrying the word fetched from its own address.
    logic        p_rst, p_adv, p_lw, p_jmp, p_iv, p_ok, p_okp;
    logic [63:0] p_tgt, p_addr;
    reg_if_id_t  prev_mo;
    logic [63:0] exp_pc = RST_PC;
    int          emitted = 0;

    always begin
        @(negedge clk);
        #2;
        p_rst  = rst;
        p_adv  = adv;
        p_lw   = lw;
        p_jmp  = jmp;
        p_tgt  = tgt;
        p_iv   = bus.ireq_valid;
        p_ok   = bus.iresp_data_ok;
        p_addr = bus.ireq_addr;
        p_okp  = okp;
        @(posedge clk);
        #1;
        if (p_rst || rst) begin
            exp_pc = RST_PC;
            chkmo("mon_rst_mo", mo, '0);
            chk1("mon_rst_iv", bus.ireq_valid, 1'b0);
        end else begin
            if (p_iv && !p_ok) begin
                chk1("bus_stable_valid", bus.ireq_valid, 1'b1);
                chk64("bus_stable_addr", bus.ireq_addr, p_addr);
            end
            if (!p_adv) begin
                chkmo("stall_mo_unchanged", mo, prev_mo);
            end else if (p_jmp) begin
                chk1("jmp_okp", p_okp, 1'b1);
                chk1("jmp_bubble", mo.valid, 1'b0);
                exp_pc = p_tgt;
            end else if (p_lw) begin
                chk1("lw_bubble", mo.valid, 1'b0);
            end else begin
                chk1("adv_valid_vs_okp", mo.valid, p_okp);
                if (mo.valid) begin
                    chk64("seq_pc", mo.pc, exp_pc);
                    chk64("seq_pcplus4", mo.pcPlus4, exp_pc + 64'd4);
                    chk64("seq_instr", {32'd0, mo.instr}, {32'd0, exp_pc[31:0]});
                    chk64("seq_instraddr", mo.instrAddr, exp_pc);
                    exp_pc = exp_pc + 64'd4;
                    emitted++;
                end
            end
        end
        prev_mo = mo;
    end

    initial begin
        rst = 1'b1; adv = 1'b1; lw = 1'b0; jmp = 1'b0; tgt = '0;
        lat = 0; force_ok = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chkmo("rst_mo", mo, '0);
        chk1("rst_iv", bus.ireq_valid, 1'b0);
        chk64("rst_addr", bus.ireq_addr, RST_PC);
        chk1("rst_okp", okp, 1'b0);
        rst = 1'b0;

        // Zero-wait memory: IDLE cycle, then one instruction per edge
        @(negedge clk);
        chk1("first_iv", bus.ireq_valid, 1'b1);
        chk64("first_addr", bus.ireq_addr, RST_PC);
        chk1("first_okp", okp, 1'b1);
        chk1("first_mo_invalid", mo.valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("zw_valid", mo.valid, 1'b1);
            chk64("zw_pc", mo.pc, RST_PC + 64'(4 * i));
            chk64("zw_pcplus4", mo.pcPlus4, RST_PC + 64'(4 * i + 4));
        end

        // One-cycle decode hold at pc 0x8000_0010
        lw = 1'b1;
        @(negedge clk);
        chk1("lw_bubble_v", mo.valid, 1'b0);
        chk1("lw_hold_iv", bus.ireq_valid, 1'b0);
        lw = 1'b0;
        @(negedge clk);
        chk1("lw_after_v", mo.valid, 1'b1);
        chk64("lw_after_pc", mo.pc, RST_PC + 64'h10);
        @(negedge clk);
        chk64("lw_next_pc", mo.pc, RST_PC + 64'h14);

        // 3-cycle memory latency: stable request, outputs 4 cycles apart
        lat = 3;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk1("lat_iv", bus.ireq_valid, 1'b1);
                chk64("lat_addr", bus.ireq_addr, RST_PC + 64'(24 + 4 * k));
                chk1("lat_gap", mo.valid, 1'b0);
            end
            @(negedge clk);
            chk1("lat_out_v", mo.valid, 1'b1);
            chk64("lat_out_pc", mo.pc, RST_PC + 64'(24 + 4 * k));
        end

        // Data arrives during a 2-cycle global stall
        lat = 0; adv = 1'b0;
        @(negedge clk);
        chk1("stall_iv0", bus.ireq_valid, 1'b0);
        chk64("stall_mo_pc0", mo.pc, RST_PC + 64'h1C);
        @(negedge clk);
        chk1("stall_iv1", bus.ireq_valid, 1'b0);
        chk64("stall_mo_pc1", mo.pc, RST_PC + 64'h1C);
        adv = 1'b1;
        @(negedge clk);
        chk1("stall_out_v", mo.valid, 1'b1);
        chk64("stall_out_pc", mo.pc, RST_PC + 64'h20);
        @(negedge clk);
        chk64("stall_next_pc", mo.pc, RST_PC + 64'h24);

        // Redirect with request outstanding, re-redirect during drain
        lat = 3;
        @(negedge clk);
        jmp = 1'b1; tgt = RST_PC + 64'h100;
        #1;
        chk1("jmp_okp_comb", okp, 1'b1);
        @(negedge clk);
        chk1("drop_iv", bus.ireq_valid, 1'b1);
        chk64("drop_stale_addr", bus.ireq_addr, RST_PC + 64'h28);
        chk1("drop_mo_v", mo.valid, 1'b0);
        tgt = RST_PC + 64'h200;
        @(negedge clk);
        jmp = 1'b0;
        chk64("drop_stale_addr2", bus.ireq_addr, RST_PC + 64'h28);
        @(negedge clk);
        chk1("refetch_iv", bus.ireq_valid, 1'b1);
        chk64("refetch_addr", bus.ireq_addr, RST_PC + 64'h200);
        chk1("refetch_mo_v", mo.valid, 1'b0);
        lat = 0;
        @(negedge clk);
        chk1("target_v", mo.valid, 1'b1);
        chk64("target_pc", mo.pc, RST_PC + 64'h200);
        chk64("target_instr", {32'd0, mo.instr}, 64'h0000_0000_8000_0200);

        // Reset mid-request, response arrives during and after reset
        lat = 3;
        @(negedge clk);
        rst = 1'b1; force_ok = 1'b1;
        #1;
        chkmo("midrst_mo", mo, '0);
        chk1("midrst_iv", bus.ireq_valid, 1'b0);
        chk64("midrst_addr", bus.ireq_addr, RST_PC);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("idle_ignore_v", mo.valid, 1'b0);
        chk1("restart_iv", bus.ireq_valid, 1'b1);
        chk64("restart_addr", bus.ireq_addr, RST_PC);
        force_ok = 1'b0; lat = 0;
        @(negedge clk);
        chk1("restart_out_v", mo.valid, 1'b1);
        chk64("restart_out_pc", mo.pc, RST_PC);

        // Randomised traffic checked by the stream model
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (jmp && adv) jmp = 1'b0;
            adv = ($urandom_range(0, 3) != 0);
            lw  = ($urandom_range(0, 6) == 0);
            if (!jmp && ($urandom_range(0, 15) == 0)) begin
                jmp = 1'b1;
                if ($urandom_range(0, 5) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                else tgt = RST_PC + 64'($urandom_range(0, 1023)) * 64'd4;
            end
            if ($urandom_range(0, 9) == 0) lat = $urandom_range(0, 3);
        end
        @(negedge clk);
        if (jmp && adv) jmp = 1'b0;
        adv = 1'b1; lw = 1'b0; lat = 0;
        @(negedge clk);
        jmp = 1'b0;
        repeat (5) @(negedge clk);
        chk1("random_made_progress", emitted > 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
